// File: rtl/periph_req2apb_bridge_pkg.sv
//--------------------------------------------------------------------
// Module  : periph_bridge_pkg
// Brief   : Shared types and constants for the core-to-APB bridge.
// Rev     : 1.0
//--------------------------------------------------------------------
`default_nettype none

package periph_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } bridge_state_e;

    localparam int BRIDGE_TIMEOUT_DEFAULT = 255;

    // Counter must reach TIMEOUT_CYCLES itself, so size for timeout+1 values.
    function automatic int bridge_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage : periph_bridge_pkg

`default_nettype wire

// File: rtl/periph_req2apb_bridge_if.sv
//--------------------------------------------------------------------
// Module  : periph_req_if / periph_apb_if
// Brief   : Core request/grant/rvalid port and APB3 bus bundles.
// Rev     : 1.0
//--------------------------------------------------------------------
`default_nettype none

interface periph_req_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
);
    logic                  req;
    logic                  gnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface : periph_req_if

interface periph_apb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface : periph_apb_if

`default_nettype wire

// File: rtl/periph_bridge_timeout.sv
//--------------------------------------------------------------------
// Module  : periph_bridge_timeout
// Brief   : Clearable wait-state counter with terminal-count flag.
// Rev     : 1.0
//--------------------------------------------------------------------
`default_nettype none

module periph_bridge_timeout #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_counter
            logic [CNT_WIDTH-1:0] r_count;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_count <= '0;
                end else if (clr_i) begin
                    r_count <= '0;
                end else if (en_i && (r_count != CNT_WIDTH'(TIMEOUT_CYCLES))) begin
                    r_count <= r_count + CNT_WIDTH'(1);
                end
            end

            // Flag fires on the wait cycle that brings the count to the limit.
            assign tc_o = en_i && (r_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
        end else begin : g_tied_off
            assign tc_o = 1'b0;
        end
    endgenerate

endmodule : periph_bridge_timeout

`default_nettype wire

// File: rtl/periph_req2apb_bridge.sv
//--------------------------------------------------------------------
// Module  : periph_req2apb_bridge
// Brief   : Core req/gnt/rvalid port to single APB3 master transfers.
// Rev     : 1.0
//--------------------------------------------------------------------
`default_nettype none

module periph_req2apb_bridge
    import periph_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = BRIDGE_TIMEOUT_DEFAULT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    periph_req_if.slave   core,
    periph_apb_if.master  apb
);

    localparam int CNT_WIDTH = bridge_cnt_width(TIMEOUT_CYCLES);

    bridge_state_e r_state;
    bridge_state_e w_state_next;

    logic                  w_gnt;
    logic                  w_reject;
    logic                  w_wait;
    logic                  w_timeout_clr;
    logic                  w_timeout_tc;
    logic                  w_rvalid;

    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    assign w_gnt    = core.req && ((r_state == IDLE) || (r_state == RESP));
    assign w_reject = core.we && (core.be != {BE_WIDTH{1'b1}});
    assign w_wait   = (r_state == ACCESS) && !apb.pready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, RESP: begin
                if (w_gnt) begin
                    w_state_next = w_reject ? RESP : SETUP;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SETUP: begin
                w_state_next = ACCESS;
            end
            ACCESS: begin
                if (apb.pready || w_timeout_tc) begin
                    w_state_next = RESP;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_timeout_clr = (w_state_next == SETUP);

    periph_bridge_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_timeout (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (w_timeout_clr),
        .en_i   (w_wait),
        .tc_o   (w_timeout_tc)
    );

    // APB address/data are latched at accept and held until the next accept,
    // which keeps them stable across every SETUP/ACCESS cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else if (w_gnt) begin
            r_paddr  <= core.addr & ~ADDR_WIDTH'(3);
            r_pwrite <= core.we;
            if (core.we) begin
                r_pwdata <= core.wdata;
            end
            r_rdata  <= '0;
            r_err    <= w_reject;
        end else if (r_state == ACCESS) begin
            if (apb.pready) begin
                r_rdata <= r_pwrite ? '0 : apb.prdata;
                r_err   <= apb.pslverr;
            end else if (w_timeout_tc) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    assign w_rvalid    = (r_state == RESP);

    assign core.gnt    = w_gnt;
    assign core.rvalid = w_rvalid;
    assign core.rdata  = w_rvalid ? r_rdata : '0;
    assign core.err    = w_rvalid && r_err;

    assign apb.paddr   = r_paddr;
    assign apb.pwdata  = r_pwdata;
    assign apb.pwrite  = r_pwrite;
    assign apb.psel    = (r_state == SETUP) || (r_state == ACCESS);
    assign apb.penable = (r_state == ACCESS);

endmodule : periph_req2apb_bridge

`default_nettype wire

// File: tb/tb_periph_req2apb_bridge.sv
//--------------------------------------------------------------------
// Module  : tb_periph_req2apb_bridge
// Brief   : Directed cycle-vector bench for the core-to-APB bridge.
// Rev     : 1.0
//--------------------------------------------------------------------
`default_nettype none

module tb_periph_req2apb_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    periph_req_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) core ();
    periph_apb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

    periph_req2apb_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .BE_WIDTH       (BW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .core   (core),
        .apb    (apb)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
        logic        gnt;
        logic        psel;
        logic        penable;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
        logic        chk_bus;
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic req, input logic we, input logic [3:0] be,
        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] prdata,
        input logic pready, input logic pslverr,
        input logic gnt, input logic psel, input logic penable, input logic rvalid,
        input logic [31:0] rdata, input logic err,
        input logic chk_bus, input logic [31:0] paddr, input logic pwrite, input logic [31:0] pwdata);
        vec_t v;
        v.req = req; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
        v.prdata = prdata; v.pready = pready; v.pslverr = pslverr;
        v.gnt = gnt; v.psel = psel; v.penable = penable; v.rvalid = rvalid;
        v.rdata = rdata; v.err = err;
        v.chk_bus = chk_bus; v.paddr = paddr; v.pwrite = pwrite; v.pwdata = pwdata;
        return v;
    endfunction

    task automatic drive(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] prdata, input logic pready, input logic pslverr);
        core.req = req; core.we = we; core.be = be; core.addr = addr; core.wdata = wdata;
        apb.prdata = prdata; apb.pready = pready; apb.pslverr = pslverr;
    endtask

    // Single read with a bounded wait for the response.
    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] data);
        bit seen = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 4'hF, addr, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check({tag, " gnt"}, 32'(core.gnt), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, data, 1'b1, 1'b0);
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (core.rvalid) begin
                seen = 1'b1;
                check({tag, " rdata"}, core.rdata, data);
                check({tag, " err"}, 32'(core.err), 32'd0);
            end
            if (!seen) @(posedge clk);
        end
        check({tag, " rvalid seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int grants;
        int resps;
        logic [31:0] exp_bb_rdata [3];
        logic        exp_bb_err   [3];

        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Read, zero wait states: accept c0, SETUP c1, ACCESS c2, rvalid c3.
        vecs.push_back(mk(1,0,4'hF,32'h1A10_1004,0,0,0,0, 1,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,0,4'hF,0,0,0,0,0,             0,1,0,0,0,0, 1,32'h1A10_1004,0,0));
        vecs.push_back(mk(0,0,4'hF,0,0,32'hCAFE_F00D,1,0, 0,1,1,0,0,0, 1,32'h1A10_1004,0,0));
        vecs.push_back(mk(0,0,4'hF,0,0,0,0,0,             0,0,0,1,32'hCAFE_F00D,0, 0,0,0,0));
        vecs.push_back(mk(0,0,4'hF,0,0,0,0,0,             0,0,0,0,0,0, 0,0,0,0));
        // Write, three wait states; core inputs change but APB bus must hold.
        vecs.push_back(mk(1,1,4'hF,32'h1A10_2008,32'h1234_5678,0,0,0, 1,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,0,4'hF,32'hFFFF_FFFC,32'hFFFF_FFFF,0,0,0, 0,1,0,0,0,0, 1,32'h1A10_2008,1,32'h1234_5678));
        vecs.push_back(mk(0,0,4'hF,32'hFFFF_FFFC,32'hFFFF_FFFF,0,0,0, 0,1,1,0,0,0, 1,32'h1A10_2008,1,32'h1234_5678));
        vecs.push_back(mk(0,0,4'hF,32'hFFFF_FFFC,32'hFFFF_FFFF,0,0,0, 0,1,1,0,0,0, 1,32'h1A10_2008,1,32'h1234_5678));
        vecs.push_back(mk(0,0,4'hF,32'hFFFF_FFFC,32'hFFFF_FFFF,0,0,0, 0,1,1,0,0,0, 1,32'h1A10_2008,1,32'h1234_5678));
        vecs.push_back(mk(0,0,4'hF,32'hFFFF_FFFC,32'hFFFF_FFFF,32'hDEAD_BEEF,1,0, 0,1,1,0,0,0, 1,32'h1A10_2008,1,32'h1234_5678));
        vecs.push_back(mk(0,0,4'hF,0,0,0,0,0,             0,0,0,1,0,0, 0,0,0,0));
        // Partial-word write: rejected, no APB select, error response next cycle.
        vecs.push_back(mk(1,1,4'h3,32'h1A10_3000,32'hAAAA_5555,0,1,0, 1,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,0,4'hF,0,0,0,1,0,             0,0,0,1,0,1, 0,0,0,0));
        vecs.push_back(mk(0,0,4'hF,0,0,0,1,0,             0,0,0,0,0,0, 0,0,0,0));

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst psel",    32'(apb.psel),    32'd0);
        check("rst penable", 32'(apb.penable), 32'd0);
        check("rst rvalid",  32'(core.rvalid), 32'd0);
        check("rst rdata",   core.rdata,       32'd0);
        check("rst err",     32'(core.err),    32'd0);
        check("rst paddr",   apb.paddr,        32'd0);
        check("rst pwrite",  32'(apb.pwrite),  32'd0);
        check("rst pwdata",  apb.pwdata,       32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
                  vecs[i].prdata, vecs[i].pready, vecs[i].pslverr);
            @(negedge clk);
            check($sformatf("v%0d gnt", i),     32'(core.gnt),    32'(vecs[i].gnt));
            check($sformatf("v%0d psel", i),    32'(apb.psel),    32'(vecs[i].psel));
            check($sformatf("v%0d penable", i), 32'(apb.penable), 32'(vecs[i].penable));
            check($sformatf("v%0d rvalid", i),  32'(core.rvalid), 32'(vecs[i].rvalid));
            check($sformatf("v%0d rdata", i),   core.rdata,       vecs[i].rdata);
            check($sformatf("v%0d err", i),     32'(core.err),    32'(vecs[i].err));
            if (vecs[i].chk_bus) begin
                check($sformatf("v%0d paddr", i),  apb.paddr,        vecs[i].paddr);
                check($sformatf("v%0d pwrite", i), 32'(apb.pwrite),  32'(vecs[i].pwrite));
                check($sformatf("v%0d pwdata", i), apb.pwdata,       vecs[i].pwdata);
            end
        end

        // Back-to-back reads with req held; slave error on the second only.
        exp_bb_rdata = '{32'h5A5A_0001, 32'h5A5A_0002, 32'h5A5A_0003};
        exp_bb_err   = '{1'b0, 1'b1, 1'b0};
        grants = 0;
        resps  = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            drive(grants < 3, 1'b0, 4'hF, 32'h1A10_5000 + 32'(grants * 4), 32'h0,
                  32'h5A5A_0000 | 32'(grants), 1'b1, grants == 2);
            @(negedge clk);
            check($sformatf("bb c%0d gnt", c),    32'(core.gnt),    32'(c == 0 || c == 3 || c == 6));
            check($sformatf("bb c%0d rvalid", c), 32'(core.rvalid), 32'(c == 3 || c == 6 || c == 9));
            if (core.gnt) grants++;
            if (core.rvalid && resps < 3) begin
                check($sformatf("bb r%0d rdata", resps), core.rdata,    exp_bb_rdata[resps]);
                check($sformatf("bb r%0d err", resps),   32'(core.err), 32'(exp_bb_err[resps]));
                resps++;
            end
        end
        check("bb responses", 32'(resps), 32'd3);

        // Hung slave: four ACCESS cycles, then error response with zero data.
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            drive(c == 0, 1'b0, 4'hF, 32'h1A10_4010, 32'h0, 32'hBAD0_BAD0, 1'b0, 1'b0);
            @(negedge clk);
            check($sformatf("to c%0d gnt", c),     32'(core.gnt),    32'(c == 0));
            check($sformatf("to c%0d psel", c),    32'(apb.psel),    32'(c >= 1 && c <= 5));
            check($sformatf("to c%0d penable", c), 32'(apb.penable), 32'(c >= 2 && c <= 5));
            check($sformatf("to c%0d rvalid", c),  32'(core.rvalid), 32'(c == 6));
            if (c == 6) begin
                check("to rdata", core.rdata,    32'h0);
                check("to err",   32'(core.err), 32'd1);
            end
        end
        do_read("post-to read", 32'h1A10_4014, 32'h600D_F00D);

        // Reset pulsed during ACCESS.
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 4'hF, 32'h1A10_6000, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 4'hF, 32'h0, 32'h0, 32'h1111_2222, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("rs access penable", 32'(apb.penable), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("rs async psel",    32'(apb.psel),    32'd0);
        check("rs async penable", 32'(apb.penable), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apb.pready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("rs c%0d rvalid", c), 32'(core.rvalid), 32'd0);
            check($sformatf("rs c%0d psel", c),   32'(apb.psel),    32'd0);
        end
        do_read("post-rst read", 32'h1A10_6004, 32'h0123_ABCD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_periph_req2apb_bridge

`default_nettype wire
